// File: rtl/linear_network_multicast_injector.sv
// Injection stage feeding the head of the linear multicast chain.
// Buffers (data, destination mask) entries from a producer and issues at most
// one per cycle as registered valid/data/en/cmd. Zero-mask entries are dropped
// when popped. Optional issue/drop counters: define LINEAR_NET_INJ_STATS_EN.
module linear_network_multicast_injector #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_NODE-1:0]   i_dest,
  input  logic                  i_issue_en,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic                  o_en,
  output logic [NUM_NODE-1:0]   o_cmd,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty
`ifdef LINEAR_NET_INJ_STATS_EN
  ,
  output logic [31:0]           o_issued_cnt,
  output logic [31:0]           o_dropped_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_WIDTH + NUM_NODE;

  // Entry storage: {data, mask}. No reset so it maps onto plain RAM.
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_NODE-1:0]   cmd_q, cmd_d;
  logic                  en_q, en_d;
`ifdef LINEAR_NET_INJ_STATS_EN
  logic [31:0]           issued_q, issued_d;
  logic [31:0]           dropped_q, dropped_d;
`endif

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         head_entry;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_NODE-1:0]   head_mask;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  // Flush suppresses both sides; a full buffer ignores the producer even if
  // a pop frees a slot on the same edge.
  assign push       = i_valid && !full && !i_flush;
  assign pop        = i_issue_en && !empty && !i_flush;
  assign head_entry = mem[rd_ptr_q];
  assign head_data  = head_entry[EW-1:NUM_NODE];
  assign head_mask  = head_entry[NUM_NODE-1:0];

  // Next-state: pointers, occupancy and the chain-facing output register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    data_d   = '0;
    cmd_d    = '0;
    en_d     = i_issue_en;
`ifdef LINEAR_NET_INJ_STATS_EN
    issued_d  = issued_q;
    dropped_d = dropped_q;
`endif
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (head_mask != '0) begin
          valid_d = 1'b1;
          data_d  = head_data;
          cmd_d   = head_mask;
`ifdef LINEAR_NET_INJ_STATS_EN
          issued_d = issued_q + 32'd1;
`endif
        end else begin
`ifdef LINEAR_NET_INJ_STATS_EN
          dropped_d = dropped_q + 32'd1;
`endif
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      cmd_q    <= '0;
      en_q     <= 1'b0;
`ifdef LINEAR_NET_INJ_STATS_EN
      issued_q  <= '0;
      dropped_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      cmd_q    <= cmd_d;
      en_q     <= en_d;
`ifdef LINEAR_NET_INJ_STATS_EN
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
`endif
    end
  end

  // Entry write into storage at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {i_data_bus, i_dest};
    end
  end

  assign o_ready    = !full;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count_q;
  assign o_valid    = valid_q;
  assign o_data_bus = data_q;
  assign o_cmd      = cmd_q;
  assign o_en       = en_q;
`ifdef LINEAR_NET_INJ_STATS_EN
  assign o_issued_cnt  = issued_q;
  assign o_dropped_cnt = dropped_q;
`endif

endmodule

// File: tb/tb_linear_network_multicast_injector.sv
// Self-checking bench for linear_network_multicast_injector: directed scenarios
// followed by random traffic, all compared against a queue-based model.
module tb_linear_network_multicast_injector;

  localparam int DW = 32;
  localparam int NN = 4;
  localparam int FD = 4;
  localparam int CW = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data_bus;
  logic [NN-1:0] i_dest;
  logic          i_issue_en;
  logic          i_flush;
  logic          o_valid;
  logic [DW-1:0] o_data_bus;
  logic          o_en;
  logic [NN-1:0] o_cmd;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;
`ifdef LINEAR_NET_INJ_STATS_EN
  logic [31:0]   o_issued_cnt;
  logic [31:0]   o_dropped_cnt;
`endif

  linear_network_multicast_injector #(
    .DATA_WIDTH(DW), .NUM_NODE(NN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_data_bus(i_data_bus), .i_dest(i_dest),
    .i_issue_en(i_issue_en), .i_flush(i_flush),
    .o_valid(o_valid), .o_data_bus(o_data_bus), .o_en(o_en), .o_cmd(o_cmd),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
`ifdef LINEAR_NET_INJ_STATS_EN
    , .o_issued_cnt(o_issued_cnt), .o_dropped_cnt(o_dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NN-1:0] mask;
  } entry_t;

  // Reference model state
  entry_t        q[$];
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [NN-1:0] exp_cmd;
  logic          exp_en;
  int unsigned   exp_issued;
  int unsigned   exp_dropped;

  int errs   = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_valid = 1'b0; exp_data = '0; exp_cmd = '0; exp_en = 1'b0;
    exp_issued = 0; exp_dropped = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check_value({ctx, ".valid"}, 64'(o_valid), 64'(exp_valid));
    check_value({ctx, ".data"},  64'(o_data_bus), 64'(exp_data));
    check_value({ctx, ".cmd"},   64'(o_cmd), 64'(exp_cmd));
    check_value({ctx, ".en"},    64'(o_en), 64'(exp_en));
    check_value({ctx, ".count"}, 64'(o_count), 64'(q.size()));
    check_value({ctx, ".full"},  64'(o_full), 64'(q.size() == FD));
    check_value({ctx, ".empty"}, 64'(o_empty), 64'(q.size() == 0));
    check_value({ctx, ".ready"}, 64'(o_ready), 64'(q.size() != FD));
`ifdef LINEAR_NET_INJ_STATS_EN
    check_value({ctx, ".issued"},  64'(o_issued_cnt), 64'(exp_issued));
    check_value({ctx, ".dropped"}, 64'(o_dropped_cnt), 64'(exp_dropped));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, clock, compare.
  task automatic step(input string ctx, input logic v, input logic [DW-1:0] d,
                      input logic [NN-1:0] m, input logic ie, input logic fl);
    bit was_full;
    entry_t e;
    i_valid = v; i_data_bus = d; i_dest = m; i_issue_en = ie; i_flush = fl;
    was_full  = (q.size() == FD);
    exp_valid = 1'b0; exp_data = '0; exp_cmd = '0; exp_en = ie;
    if (fl) begin
      q.delete();
    end else begin
      if (ie && q.size() > 0) begin
        e = q.pop_front();
        if (e.mask != '0) begin
          exp_valid = 1'b1; exp_data = e.data; exp_cmd = e.mask;
          exp_issued++;
        end else begin
          exp_dropped++;
        end
      end
      if (v && !was_full) q.push_back('{data: d, mask: m});
    end
    @(posedge clk);
    #1;
    $display("[%0t] %s v=%0b d=%h m=%b ie=%0b fl=%0b -> o_valid=%0b o_data=%h o_cmd=%b o_en=%0b cnt=%0d",
             $time, ctx, v, d, m, ie, fl, o_valid, o_data_bus, o_cmd, o_en, o_count);
    check_outputs(ctx);
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 0; i_data_bus = '0; i_dest = '0; i_issue_en = 0; i_flush = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Basic issue
    step("basic", 1, 32'hAAAAAAAA, 4'b0001, 1, 0);
    step("basic", 0, 0, 0, 1, 0);
    check_value("basic.issued_data", 64'(o_data_bus), 64'h0AAAAAAAA);
    step("basic", 0, 0, 0, 1, 0);

    // Fill and full, then drain in order
    for (int i = 1; i <= 5; i++) step("fill", 1, DW'(i), 4'b1110, 0, 0);
    check_value("fill.full_flag", 64'(o_full), 64'd1);
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 0, 1, 0);
    check_value("drain.empty_flag", 64'(o_empty), 64'd1);

    // Wrap-around with sustained push and pop
    for (int i = 0; i < 10; i++) step("wrap", 1, DW'(32'h10 + i), 4'b0101, 1, 0);
    step("wrap", 0, 0, 0, 1, 0);
    step("wrap", 0, 0, 0, 1, 0);

    // Zero-mask drop
    step("drop", 1, 32'hBBBBBBBB, 4'b0000, 0, 0);
    step("drop", 1, 32'hCCCCCCCC, 4'b1000, 0, 0);
    for (int i = 0; i < 3; i++) step("drop", 0, 0, 0, 1, 0);

    // Stall mid-stream
    for (int i = 0; i < 3; i++) step("stall_fill", 1, DW'(32'h30 + i), 4'b0011, 0, 0);
    step("stall", 0, 0, 0, 1, 0);
    step("stall", 0, 0, 0, 0, 0);
    step("stall", 0, 0, 0, 1, 0);
    step("stall", 0, 0, 0, 1, 0);
    step("stall", 0, 0, 0, 0, 0);

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) step("flush_fill", 1, DW'(32'h40 + i), 4'b1111, 0, 0);
    step("flush", 1, 32'h4F, 4'b1111, 1, 1);
    step("flush", 0, 0, 0, 1, 0);

    // Asynchronous reset between edges
    for (int i = 0; i < 2; i++) step("areset_fill", 1, DW'(32'h50 + i), 4'b0110, 0, 0);
    step("areset_fill", 0, 0, 0, 1, 0);
    #3; rst_n = 1'b0;
    i_valid = 0; i_issue_en = 0; i_flush = 0;
    #1;
    model_reset();
    check_outputs("areset");
    #2; rst_n = 1'b1;
    step("post_reset", 0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [NN-1:0] m;
      m = ($urandom_range(0, 4) == 0) ? '0 : NN'($urandom);
      step("rand", $urandom_range(0, 3) != 0, $urandom, m,
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/linear_network_multicast_injector.md
Name: linear_network_multicast_injector

Overview:
- Injection stage sitting directly upstream of the sequential linear multicast chain.
- Buffers (data, destination multi-hot mask) entries from a producer using a valid/ready handshake.
- Issues at most one entry per cycle into the chain's head as registered i_valid / i_data_bus / i_en / i_cmd.
- Provides flush, occupancy status and drop of zero-mask entries.

Parameters:
- DATA_WIDTH, 32, width of one data word.
- NUM_NODE, 4, number of chain nodes; width of the destination mask.
- FIFO_DEPTH, 4, number of buffered entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous assert, active-low
- i_valid  input  1  producer entry valid
- o_ready  output  1  injector can accept an entry; equals !o_full
- i_data_bus  input  DATA_WIDTH  producer data
- i_dest  input  NUM_NODE  destination mask; bit k set means node k receives the word
- i_issue_en  input  1  controller permission to issue into the chain
- i_flush  input  1  synchronous discard of all buffered entries
- o_valid  output  1  to chain i_valid
- o_data_bus  output  DATA_WIDTH  to chain i_data_bus
- o_en  output  1  to chain i_en
- o_cmd  output  NUM_NODE  to chain i_cmd
- o_count  output  clog2(FIFO_DEPTH+1)  current occupancy
- o_full  output  1  occupancy == FIFO_DEPTH
- o_empty  output  1  occupancy == 0

Behaviour:
- **Reset (async, rst_n low):**
  - Read and write pointers = 0, o_count = 0, o_empty = 1, o_full = 0, o_ready = 1.
  - o_valid = 0, o_data_bus = 0, o_cmd = 0, o_en = 0.
  - Release is synchronous to the clk edge.
  - Reset mid-operation discards all entries and the output register.
- **Push:** on an edge where i_valid && o_ready, write {i_data_bus, i_dest} at the write pointer and increment it.
  - When full, o_ready = 0 and i_valid is ignored, even if a pop occurs on the same edge. No write-through-on-pop.
- **Pop:** on an edge where i_issue_en && !o_empty && !i_flush, read the head and increment the read pointer.
- **Output register, updated every edge:**
  - Pop with nonzero mask: o_valid = 1, o_data_bus = head data, o_cmd = head mask.
  - Pop with all-zero mask: the entry is dropped. It consumes the pop slot; o_valid = 0, o_data_bus = 0, o_cmd = 0.
  - No pop: o_valid = 0, o_data_bus = 0, o_cmd = 0.
  - o_en = i_issue_en registered, so a stalled controller also freezes the chain.
- **Latency:** an entry pushed on edge E appears on the outputs after edge E+1 at the earliest (no fall-through). Sustained throughput is 1 entry per cycle.
- **Simultaneous push and pop when not full:** both happen; occupancy is unchanged.
- **Pointers:** wrap modulo FIFO_DEPTH. An extra wrap bit (or o_count) distinguishes full from empty.
- **Flush:** highest priority after reset. On the edge where i_flush = 1:
  - Pointers and occupancy go to 0.
  - A concurrent push is discarded.
  - No pop occurs; o_valid = 0 next cycle; o_en still follows i_issue_en.
- **Status signals:** o_count, o_full and o_empty are registered-state derived, valid the cycle after each edge.

Optional Feature:
- Macro: LINEAR_NET_INJ_STATS_EN.
- With the macro defined, add ports:
  - o_issued_cnt  output  32  increments once per pop with nonzero mask.
  - o_dropped_cnt  output  32  increments once per zero-mask pop.
- Counter rules:
  - Both reset to 0.
  - Both wrap at 2^32.
  - Neither is cleared by i_flush.
- With the macro undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- **Basic issue:** reset, then push data 0xAAAAAAAA with mask 4'b0001, i_issue_en = 1. Response: two edges later o_valid = 1, o_data_bus = 0xAAAAAAAA, o_cmd = 4'b0001, o_en = 1. The following cycle o_valid = 0, o_data_bus = 0.
- **Fill and full:** i_issue_en = 0; push 0x1, 0x2, 0x3, 0x4 (masks 4'b1110), then push 0x5. Response: after 4 pushes o_full = 1, o_ready = 0, o_count = 4; 0x5 is not stored. Raising i_issue_en then yields 0x1 to 0x4 in order, one per cycle, each with o_cmd = 4'b1110, then o_empty = 1.
- **Wrap-around:** sustained push and pop for 10 entries (0x10 to 0x19) with i_issue_en = 1. Response: output order matches input order, o_count stays at 1 or below, no entry is lost.
- **Zero-mask drop:** push 0xBBBBBBBB with mask 0, then 0xCCCCCCCC with mask 4'b1000. Response: no o_valid for 0xBB; 0xCC is issued with o_cmd = 4'b1000 (o_dropped_cnt = 1 when LINEAR_NET_INJ_STATS_EN is defined).
- **Stall mid-stream:** 3 entries buffered; i_issue_en toggles 1,0,1,1. Response: o_en follows the toggles one cycle later; o_valid = 0 during the stall cycle; entries still issue in order.
- **Flush and reset:** 3 entries buffered; assert i_flush for 1 cycle together with a push. Response: o_count = 0, o_empty = 1, nothing issued. Then 2 entries are buffered and rst_n is asserted asynchronously between edges. Response: all outputs go to reset values immediately.
